rc4_crack_coordinator: RTL and testbench

//  Parametrised N-core RC4 key-search coordinator. Splits the KEY_W-bit keyspace evenly across
//  NUM_CORES cracker cores, launches them together and arbitrates their results. It latches the

---
 rtl/rc4_crack_coordinator.sv | 175 +++++++++++++++++
 tb/tb_rc4_crack_coordinator.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/rc4_crack_coordinator.sv
// RC4 key-search coordinator: partitions the keyspace across NUM_CORES cracker cores,
// launches them, latches the first hit (lowest index wins) or reports exhaustion.
module rc4_crack_coordinator #(
  parameter int NUM_CORES = 4,
  parameter int KEY_W     = 22,
  parameter int SECRET_W  = 24,
  parameter int CNT_W     = 32,
  localparam int WIN_W    = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          start,
  input  logic [NUM_CORES-1:0]          core_found,
  input  logic [NUM_CORES-1:0]          core_done,
  input  logic [NUM_CORES*SECRET_W-1:0] core_key,
  output logic [NUM_CORES*KEY_W-1:0]    core_base,
  output logic [NUM_CORES*KEY_W-1:0]    core_end,
  output logic [NUM_CORES-1:0]          core_start,
  output logic [NUM_CORES-1:0]          core_halt,
  output logic [SECRET_W-1:0]           key,
  output logic                          key_valid,
  output logic [WIN_W-1:0]              winner,
  output logic                          busy,
  output logic                          exhausted,
  output logic [CNT_W-1:0]              search_cycles
);

  localparam int unsigned SPAN = (2 ** KEY_W) / NUM_CORES;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_SEARCH = 3'd2,
    ST_FOUND  = 3'd3,
    ST_FAIL   = 3'd4
  } state_t;

  state_t                 state_r, state_s;
  logic [SECRET_W-1:0]    key_r, key_s;
  logic                   key_valid_r, key_valid_s;
  logic [WIN_W-1:0]       winner_r, winner_s;
  logic                   busy_r, busy_s;
  logic                   exhausted_r, exhausted_s;
  logic [CNT_W-1:0]       cnt_r, cnt_s;
  logic [NUM_CORES-1:0]   mask_r, mask_s;
  logic                   first_r, first_s;
  logic                   start_r, start_s;
  logic                   halt_r, halt_s;

  // Lowest set bit index of the found vector.
  function automatic logic [WIN_W-1:0] lowest_set(input logic [NUM_CORES-1:0] v);
    logic [WIN_W-1:0] idx;
    idx = {WIN_W{1'b0}};
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (v[i]) begin
        idx = WIN_W'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  for (genvar g = 0; g < NUM_CORES; g++) begin : g_part
    assign core_base[g*KEY_W +: KEY_W] = KEY_W'(g * SPAN);
    assign core_end[g*KEY_W +: KEY_W]  = KEY_W'(g * SPAN + SPAN - 1);
  end

  // Next-state and next-output computation.
  always_comb begin
    state_s     = state_r;
    key_s       = key_r;
    key_valid_s = key_valid_r;
    winner_s    = winner_r;
    exhausted_s = exhausted_r;
    cnt_s       = cnt_r;
    mask_s      = mask_r;
    busy_s      = 1'b0;
    start_s     = 1'b0;
    halt_s      = 1'b1;
    first_s     = (state_r == ST_LAUNCH);

    case (state_r)
      ST_IDLE, ST_FOUND, ST_FAIL: begin
        if (start) state_s = ST_LAUNCH;
        else       state_s = state_r;
      end
      ST_LAUNCH: state_s = ST_SEARCH;
      ST_SEARCH: begin
        cnt_s = (cnt_r == {CNT_W{1'b1}}) ? cnt_r : cnt_r + CNT_W'(1);
        // Flags seen in the first SEARCH cycle may be stale from the previous run.
        if (!first_r) begin
          mask_s = mask_r | core_done;
          if (|core_found) begin
            state_s  = ST_FOUND;
            winner_s = lowest_set(core_found);
            key_s    = core_key[lowest_set(core_found)*SECRET_W +: SECRET_W];
          end else if ((mask_r | core_done) == {NUM_CORES{1'b1}}) begin
            state_s = ST_FAIL;
          end else begin
            state_s = ST_SEARCH;
          end
        end else begin
          state_s = ST_SEARCH;
        end
      end
      default: state_s = ST_IDLE;
    endcase

    // Outputs are decoded from the next state so they register alongside it.
    case (state_s)
      ST_LAUNCH: begin
        start_s     = 1'b1;
        halt_s      = 1'b0;
        busy_s      = 1'b1;
        key_s       = {SECRET_W{1'b0}};
        key_valid_s = 1'b0;
        winner_s    = {WIN_W{1'b0}};
        exhausted_s = 1'b0;
        cnt_s       = {CNT_W{1'b0}};
        mask_s      = {NUM_CORES{1'b0}};
      end
      ST_SEARCH: begin
        halt_s = 1'b0;
        busy_s = 1'b1;
      end
      ST_FOUND: key_valid_s = 1'b1;
      ST_FAIL: begin
        exhausted_s = 1'b1;
        key_valid_s = 1'b0;
        key_s       = {SECRET_W{1'b0}};
      end
      default: halt_s = 1'b1;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r     <= ST_IDLE;
      key_r       <= {SECRET_W{1'b0}};
      key_valid_r <= 1'b0;
      winner_r    <= {WIN_W{1'b0}};
      busy_r      <= 1'b0;
      exhausted_r <= 1'b0;
      cnt_r       <= {CNT_W{1'b0}};
      mask_r      <= {NUM_CORES{1'b0}};
      first_r     <= 1'b0;
      start_r     <= 1'b0;
      halt_r      <= 1'b1;
    end else begin
      state_r     <= state_s;
      key_r       <= key_s;
      key_valid_r <= key_valid_s;
      winner_r    <= winner_s;
      busy_r      <= busy_s;
      exhausted_r <= exhausted_s;
      cnt_r       <= cnt_s;
      mask_r      <= mask_s;
      first_r     <= first_s;
      start_r     <= start_s;
      halt_r      <= halt_s;
    end
  end

  assign core_start    = {NUM_CORES{start_r}};
  assign core_halt     = {NUM_CORES{halt_r}};
  assign key           = key_r;
  assign key_valid     = key_valid_r;
  assign winner        = winner_r;
  assign busy          = busy_r;
  assign exhausted     = exhausted_r;
  assign search_cycles = cnt_r;

endmodule

// File: tb/tb_rc4_crack_coordinator.sv
// Directed self-checking bench for rc4_crack_coordinator (NUM_CORES=4, KEY_W=22).
module tb_rc4_crack_coordinator;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [3:0]  core_found;
  logic [3:0]  core_done;
  logic [95:0] core_key;
  logic [87:0] core_base;
  logic [87:0] core_end;
  logic [3:0]  core_start;
  logic [3:0]  core_halt;
  logic [23:0] key;
  logic        key_valid;
  logic [1:0]  winner;
  logic        busy;
  logic        exhausted;
  logic [31:0] search_cycles;

  int n_checks = 0;
  int n_pass   = 0;

  rc4_crack_coordinator #(
    .NUM_CORES(4), .KEY_W(22), .SECRET_W(24), .CNT_W(32)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .core_found(core_found), .core_done(core_done), .core_key(core_key),
    .core_base(core_base), .core_end(core_end),
    .core_start(core_start), .core_halt(core_halt),
    .key(key), .key_valid(key_valid), .winner(winner),
    .busy(busy), .exhausted(exhausted), .search_cycles(search_cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Pulse start and advance into the first SEARCH cycle.
  task automatic launch();
    start = 1'b1;
    step(1);
    start = 1'b0;
    check("launch_start", core_start, 4'hF);
    check("launch_halt", core_halt, 4'h0);
    check("launch_busy", busy, 1'b1);
    check("launch_kv", key_valid, 1'b0);
    check("launch_cnt", search_cycles, 32'd0);
    step(1);
    check("search_start", core_start, 4'h0);
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; core_found = 4'h0; core_done = 4'h0; core_key = '0;
    step(2);
    check("rst_kv", key_valid, 1'b0);
    check("rst_halt", core_halt, 4'hF);
    check("rst_busy", busy, 1'b0);
    check("rst_start", core_start, 4'h0);
    check("rst_cnt", search_cycles, 32'd0);
    check("rst_exh", exhausted, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check("base", core_base[i*22 +: 22], 64'(i * 32'h100000));
      check("end", core_end[i*22 +: 22], 64'(i * 32'h100000 + 32'hFFFFF));
    end
    reset_n = 1'b1;
    step(1);

    // Hit from core 2 on the 100th SEARCH cycle.
    launch();
    step(99);
    check("t2_busy", busy, 1'b1);
    check("t2_cnt99", search_cycles, 32'd99);
    core_found = 4'b0100;
    core_key[2*24 +: 24] = 24'h2A5F13;
    step(1);
    core_found = 4'h0;
    check("t2_key", key, 24'h2A5F13);
    check("t2_win", winner, 2'd2);
    check("t2_kv", key_valid, 1'b1);
    check("t2_halt", core_halt, 4'hF);
    check("t2_cnt", search_cycles, 32'd100);
    check("t2_busy_off", busy, 1'b0);
    core_found = 4'b0001;
    core_key[0 +: 24] = 24'hDEAD01;
    step(1);
    core_found = 4'h0;
    check("late_key", key, 24'h2A5F13);
    check("late_win", winner, 2'd2);

    // Restart from FOUND, new hit from core 0 on SEARCH cycle 5.
    launch();
    check("t6_key_clr", key, 24'h0);
    step(4);
    core_found = 4'b0001;
    core_key[0 +: 24] = 24'h000055;
    step(1);
    core_found = 4'h0;
    check("t6_key", key, 24'h000055);
    check("t6_win", winner, 2'd0);
    check("t6_kv", key_valid, 1'b1);
    check("t6_cnt", search_cycles, 32'd5);

    // First-cycle guard, then simultaneous hits on cores 1 and 3.
    launch();
    core_found = 4'b0001;
    step(1);
    core_found = 4'h0;
    check("guard_kv", key_valid, 1'b0);
    check("guard_busy", busy, 1'b1);
    core_found = 4'b1010;
    core_key[1*24 +: 24] = 24'h000011;
    core_key[3*24 +: 24] = 24'h000033;
    step(1);
    core_found = 4'h0;
    check("tie_win", winner, 2'd1);
    check("tie_key", key, 24'h000011);

    // Exhaustion: done bits at SEARCH cycles 10, 20, 30, 40.
    for (int pass = 0; pass < 2; pass++) begin
      launch();
      core_key[3*24 +: 24] = 24'hABCDEF;
      for (int c = 1; c <= 40; c++) begin
        core_done = (c == 10) ? 4'b0001 : (c == 20) ? 4'b0010 :
                    (c == 30) ? 4'b0100 : (c == 40) ? 4'b1000 : 4'b0000;
        if (c == 40) begin
          check("exh_early", exhausted, 1'b0);
          check("exh_busy", busy, 1'b1);
          if (pass == 1) core_found = 4'b1000;
        end
        step(1);
        core_done = 4'h0;
        core_found = 4'h0;
      end
      if (pass == 0) begin
        check("exh", exhausted, 1'b1);
        check("exh_kv", key_valid, 1'b0);
        check("exh_key", key, 24'h0);
        check("exh_halt", core_halt, 4'hF);
        check("exh_cnt", search_cycles, 32'd40);
      end else begin
        check("fd_exh", exhausted, 1'b0);
        check("fd_kv", key_valid, 1'b1);
        check("fd_win", winner, 2'd3);
        check("fd_key", key, 24'hABCDEF);
      end
    end

    // Start ignored mid-SEARCH, then reset mid-SEARCH.
    launch();
    step(5);
    start = 1'b1;
    step(1);
    start = 1'b0;
    check("nostart", core_start, 4'h0);
    check("nostart_busy", busy, 1'b1);
    check("nostart_cnt", search_cycles, 32'd6);
    reset_n = 1'b0;
    step(1);
    reset_n = 1'b1;
    check("mrst_busy", busy, 1'b0);
    check("mrst_halt", core_halt, 4'hF);
    check("mrst_kv", key_valid, 1'b0);
    check("mrst_cnt", search_cycles, 32'd0);
    check("mrst_key", key, 24'h0);
    check("mrst_win", winner, 2'd0);
    check("mrst_exh", exhausted, 1'b0);
    core_found = 4'b0010;
    step(3);
    core_found = 4'h0;
    check("idle_kv", key_valid, 1'b0);
    check("idle_busy", busy, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
